// File: rtl/duty_ramp_ctrl_if.sv
// Duty command / PWM-stage signal bundle between the controller and duty_ramp_ctrl.
interface duty_ramp_ctrl_if;
  logic       en;
  logic       fault;
  logic [9:0] d_cmd;
  logic [9:0] d;
  logic       pwm_en;
  logic       at_target;
  logic       faulted;

  modport master (output en, fault, d_cmd, input d, pwm_en, at_target, faulted);
  modport slave  (input en, fault, d_cmd, output d, pwm_en, at_target, faulted);
endinterface

// File: rtl/duty_ramp_ctrl.sv
// Soft-start / slew-limited duty stage feeding the PWM dead-time block.
// Optional ramp-down on disable is built when DUTY_RAMP_DOWN_EN is defined.
module duty_ramp_ctrl #(
  parameter int PERIOD = 1000,
  parameter int DMAX   = 900,
  parameter int STEP   = 5
) (
  input logic             clk,
  input logic             rst,
  duty_ramp_ctrl_if.slave bus
);
  localparam int            PW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD - 1);
  localparam logic [10:0]   DMAX_W    = 11'(DMAX);
  localparam logic [9:0]    DMAX_D    = 10'(DMAX);
  localparam logic [10:0]   STEP_W    = 11'(STEP);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RAMP  = 3'd1;
  localparam logic [2:0] S_TRACK = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [PW-1:0] pcnt_r;
  logic [2:0]    state_r, state_s;
  logic [9:0]    tgt_r, tgt_s, tgt_tick_s;
  logic [9:0]    d_r, d_s, d_step_s;
  logic          pwm_en_r, pwm_en_s;
  logic          at_target_r, at_target_s;
  logic          faulted_r, faulted_s;
  logic          tick_s;
  logic          run_s;

  function automatic logic [9:0] clamp_target(input logic [9:0] cmd);
    return ({1'b0, cmd} > DMAX_W) ? DMAX_D : cmd;
  endfunction

  // 11-bit step toward tgt; a carry into bit 10 can only mean corruption, so saturate
  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    logic [10:0] cur_w, tgt_w, gap_w, res_w;
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    if (tgt_w > cur_w) begin
      gap_w = tgt_w - cur_w;
      res_w = cur_w + ((gap_w > STEP_W) ? STEP_W : gap_w);
    end else begin
      gap_w = cur_w - tgt_w;
      res_w = cur_w - ((gap_w > STEP_W) ? STEP_W : gap_w);
    end
    return (res_w[10] == 1'b0) ? res_w[9:0] : DMAX_D;
  endfunction

  // Next-state, next-duty and next-output decode
  always_comb begin
    tick_s     = (pcnt_r == PCNT_LAST);
    tgt_tick_s = tick_s ? clamp_target(bus.d_cmd) : tgt_r;
    d_step_s   = step_toward(d_r, tgt_tick_s);
    state_s    = state_r;
    d_s        = d_r;
    if (bus.fault && (state_r != S_FAULT)) begin
      state_s = S_FAULT;
      d_s     = 10'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          d_s = 10'd0;
          if (bus.en) begin
            state_s = S_RAMP;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_RAMP, S_TRACK: begin
          if (!bus.en) begin
`ifdef DUTY_RAMP_DOWN_EN
            state_s = S_STOP;
`else
            state_s = S_IDLE;
            d_s     = 10'd0;
`endif
          end else if (tick_s) begin
            d_s = d_step_s;
            if (d_step_s == tgt_tick_s) begin
              state_s = S_TRACK;
            end else begin
              state_s = state_r;
            end
          end else begin
            state_s = state_r;
          end
        end
`ifdef DUTY_RAMP_DOWN_EN
        S_STOP: begin
          if (bus.en) begin
            state_s = S_RAMP;
          end else if (tick_s) begin
            d_s = step_toward(d_r, 10'd0);
            if (d_s == 10'd0) begin
              state_s = S_IDLE;
            end else begin
              state_s = S_STOP;
            end
          end else begin
            state_s = S_STOP;
          end
        end
`endif
        S_FAULT: begin
          d_s = 10'd0;
          if (!bus.en && !bus.fault) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_FAULT;
          end
        end
        default: begin
          state_s = S_IDLE;
          d_s     = 10'd0;
        end
      endcase
    end
    // ramp-down always heads for zero regardless of the request
    if (state_s == S_STOP) begin
      tgt_s = 10'd0;
    end else begin
      tgt_s = tgt_tick_s;
    end
    run_s       = (state_s == S_RAMP) || (state_s == S_TRACK);
    pwm_en_s    = run_s || (state_s == S_STOP);
    at_target_s = run_s && (d_s == tgt_s);
    faulted_s   = (state_s == S_FAULT);
  end

  // State, period counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_r      <= {PW{1'b0}};
      state_r     <= S_IDLE;
      tgt_r       <= 10'd0;
      d_r         <= 10'd0;
      pwm_en_r    <= 1'b0;
      at_target_r <= 1'b0;
      faulted_r   <= 1'b0;
    end else begin
      pcnt_r      <= tick_s ? {PW{1'b0}} : (pcnt_r + PW'(1));
      state_r     <= state_s;
      tgt_r       <= tgt_s;
      d_r         <= d_s;
      pwm_en_r    <= pwm_en_s;
      at_target_r <= at_target_s;
      faulted_r   <= faulted_s;
    end
  end

  assign bus.d         = d_r;
  assign bus.pwm_en    = pwm_en_r;
  assign bus.at_target = at_target_r;
  assign bus.faulted   = faulted_r;
endmodule
